// File: rtl/wb_port_arbiter.sv
// Shares one registered scoreboard writeback port among NrReq variable-latency units, one holding slot each.
// Latency: result accepted at edge n is granted in cycle n+1 and shows on wb_valid_o in cycle n+2.
// Backpressure: req_ready_o high when the slot is free or being drained this cycle, low during flush_i.
// Build option: WB_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins) instead of round-robin.
module wb_port_arbiter #(
    parameter int NrReq       = 3,
    parameter int TransIdBits = 3,
    parameter int DataW       = 64
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 flush_i,
    input  logic [NrReq-1:0]                     req_valid_i,
    output logic [NrReq-1:0]                     req_ready_o,
    input  logic [NrReq-1:0][TransIdBits-1:0]    req_trans_id_i,
    input  logic [NrReq-1:0][DataW-1:0]          req_data_i,
    input  logic [NrReq-1:0]                     req_ex_valid_i,
    input  logic [NrReq-1:0][DataW-1:0]          req_ex_cause_i,
    output logic                                 wb_valid_o,
    output logic [TransIdBits-1:0]               wb_trans_id_o,
    output logic [DataW-1:0]                     wb_data_o,
    output logic                                 wb_ex_valid_o,
    output logic [DataW-1:0]                     wb_ex_cause_o,
    output logic [$clog2(NrReq)-1:0]             wb_grant_idx_o,
    output logic                                 conflict_o
);

    localparam int IdxW = $clog2(NrReq);

    typedef struct packed {
        logic [TransIdBits-1:0] trans_id;
        logic [DataW-1:0]       data;
        logic                   ex_valid;
        logic [DataW-1:0]       ex_cause;
    } entry_t;

    entry_t           held [NrReq];
    logic [NrReq-1:0] occ;
    logic [NrReq-1:0] gnt;
    logic [NrReq-1:0] acc;
    logic             gnt_any;
    logic [IdxW-1:0]  gnt_idx;
    logic [IdxW-1:0]  cand;

    entry_t           wb_q;
    logic             wb_vld_q;
    logic [IdxW-1:0]  wb_idx_q;
    logic             conflict_q;

`ifndef WB_ARB_FIXED_PRIO_EN
    logic [IdxW-1:0]  ptr;
`endif

    // First occupied slot in search order wins; order starts at ptr in round-robin mode.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        gnt     = '0;
        for (int k = 0; k < NrReq; k++) begin
`ifdef WB_ARB_FIXED_PRIO_EN
            cand = IdxW'(k);
`else
            cand = IdxW'((int'(ptr) + k) % NrReq);
`endif
            if (!gnt_any && occ[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign req_ready_o = {NrReq{!flush_i}} & (~occ | gnt);
    assign acc         = req_valid_i & req_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ <= '0;
        end else if (flush_i) begin
            occ <= '0;
        end else begin
            for (int i = 0; i < NrReq; i++) begin
                if (acc[i]) begin
                    occ[i] <= 1'b1;
                end else if (gnt[i]) begin
                    occ[i] <= 1'b0;
                end
            end
        end
    end

    // Holding payload is qualified by occ, so it needs no reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NrReq; i++) begin
            if (acc[i]) begin
                held[i] <= '{trans_id: req_trans_id_i[i],
                             data:     req_data_i[i],
                             ex_valid: req_ex_valid_i[i],
                             ex_cause: req_ex_cause_i[i]};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_q       <= '0;
            wb_vld_q   <= 1'b0;
            wb_idx_q   <= '0;
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= ($countones(occ) > 1);
            if (!flush_i && gnt_any) begin
                wb_q     <= held[gnt_idx];
                wb_vld_q <= 1'b1;
                wb_idx_q <= gnt_idx;
            end else begin
                wb_vld_q <= 1'b0;
            end
        end
    end

`ifndef WB_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr <= '0;
        end else if (!flush_i && gnt_any) begin
            ptr <= (gnt_idx == IdxW'(NrReq - 1)) ? '0 : gnt_idx + IdxW'(1);
        end
    end
`endif

    assign wb_valid_o     = wb_vld_q;
    assign wb_trans_id_o  = wb_q.trans_id;
    assign wb_data_o      = wb_q.data;
    assign wb_ex_valid_o  = wb_q.ex_valid;
    assign wb_ex_cause_o  = wb_q.ex_cause;
    assign wb_grant_idx_o = wb_idx_q;
    assign conflict_o     = conflict_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (default round-robin build): expected writebacks, with the
// cycle they are due, are queued when results are offered and compared as the port pulses.
module tb_wb_port_arbiter;

    localparam int NrReq       = 3;
    localparam int TransIdBits = 3;
    localparam int DataW       = 64;
    localparam int IdxW        = 2;

    logic                              clk_i = 1'b0;
    logic                              rst_i;
    logic                              flush_i;
    logic [NrReq-1:0]                  req_valid_i;
    logic [NrReq-1:0]                  req_ready_o;
    logic [NrReq-1:0][TransIdBits-1:0] req_trans_id_i;
    logic [NrReq-1:0][DataW-1:0]       req_data_i;
    logic [NrReq-1:0]                  req_ex_valid_i;
    logic [NrReq-1:0][DataW-1:0]       req_ex_cause_i;
    logic                              wb_valid_o;
    logic [TransIdBits-1:0]            wb_trans_id_o;
    logic [DataW-1:0]                  wb_data_o;
    logic                              wb_ex_valid_o;
    logic [DataW-1:0]                  wb_ex_cause_o;
    logic [IdxW-1:0]                   wb_grant_idx_o;
    logic                              conflict_o;

    wb_port_arbiter #(.NrReq(NrReq), .TransIdBits(TransIdBits), .DataW(DataW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_trans_id_i (req_trans_id_i),
        .req_data_i     (req_data_i),
        .req_ex_valid_i (req_ex_valid_i),
        .req_ex_cause_i (req_ex_cause_i),
        .wb_valid_o     (wb_valid_o),
        .wb_trans_id_o  (wb_trans_id_o),
        .wb_data_o      (wb_data_o),
        .wb_ex_valid_o  (wb_ex_valid_o),
        .wb_ex_cause_o  (wb_ex_cause_o),
        .wb_grant_idx_o (wb_grant_idx_o),
        .conflict_o     (conflict_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          cyc;
        logic [2:0]  id;
        logic [63:0] data;
        logic        exv;
        logic [63:0] cause;
        logic [1:0]  idx;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input int due, input logic [2:0] id, input logic [63:0] data,
                        input logic exv, input logic [63:0] cause, input logic [1:0] idx);
        exp_t e;
        e.cyc = due; e.id = id; e.data = data; e.exv = exv; e.cause = cause; e.idx = idx;
        sb.push_back(e);
    endtask

    task automatic drive(input int i, input logic [2:0] id, input logic [63:0] data,
                         input logic exv, input logic [63:0] cause);
        req_valid_i[i]    = 1'b1;
        req_trans_id_i[i] = id;
        req_data_i[i]     = data;
        req_ex_valid_i[i] = exv;
        req_ex_cause_i[i] = cause;
    endtask

    task automatic clear();
        req_valid_i = '0;
    endtask

    // Advance one cycle, sample at the falling edge, and check the writeback port against the queue.
    task automatic step();
        exp_t e;
        @(posedge clk_i);
        cyc++;
        @(negedge clk_i);
        if (wb_valid_o) begin
            if (sb.size() == 0) begin
                chk("spurious_wb", 64'(wb_valid_o), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("wb_cycle",    64'(cyc),            64'(e.cyc));
                chk("wb_trans_id", 64'(wb_trans_id_o),  64'(e.id));
                chk("wb_data",     wb_data_o,           e.data);
                chk("wb_ex_valid", 64'(wb_ex_valid_o),  64'(e.exv));
                chk("wb_ex_cause", wb_ex_cause_o,       e.cause);
                chk("wb_grant_idx",64'(wb_grant_idx_o), 64'(e.idx));
            end
        end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
            chk("wb_missing", 64'(wb_valid_o), 64'd1);
            void'(sb.pop_front());
        end
    endtask

    task automatic drain();
        repeat (6) step();
        chk("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int c;
        rst_i          = 1'b1;
        flush_i        = 1'b0;
        req_valid_i    = '1;
        req_trans_id_i = {3'd3, 3'd2, 3'd1};
        req_data_i     = {64'h33, 64'h22, 64'h11};
        req_ex_valid_i = '1;
        req_ex_cause_i = {64'h3, 64'h2, 64'h1};
        step();
        step();
        chk("rst_wb_valid",    64'(wb_valid_o),     64'd0);
        chk("rst_wb_ex_valid", 64'(wb_ex_valid_o),  64'd0);
        chk("rst_wb_trans_id", 64'(wb_trans_id_o),  64'd0);
        chk("rst_wb_data",     wb_data_o,           64'd0);
        chk("rst_wb_ex_cause", wb_ex_cause_o,       64'd0);
        chk("rst_wb_grant",    64'(wb_grant_idx_o), 64'd0);
        chk("rst_conflict",    64'(conflict_o),     64'd0);
        rst_i = 1'b0;
        clear();
        req_ex_valid_i = '0;
        #1;
        chk("ready_after_reset", 64'(req_ready_o), 64'b111);
        step();
        chk("idle_no_wb", 64'(wb_valid_o), 64'd0);
        step();
        chk("idle_no_wb", 64'(wb_valid_o), 64'd0);

        // single requester, then back-to-back from the same slot
        c = cyc;
        drive(1, 3'd5, 64'hDEAD, 1'b0, 64'h0);
        #1 chk("ready_single", 64'(req_ready_o[1]), 64'd1);
        push(c + 2, 3'd5, 64'hDEAD, 1'b0, 64'h0, 2'd1);
        step();
        drive(1, 3'd6, 64'hBEEF, 1'b0, 64'h0);
        #1 chk("ready_b2b", 64'(req_ready_o[1]), 64'd1);
        push(c + 3, 3'd6, 64'hBEEF, 1'b0, 64'h0, 2'd1);
        step();
        drive(1, 3'd7, 64'hCAFE, 1'b0, 64'h0);
        push(c + 4, 3'd7, 64'hCAFE, 1'b0, 64'h0, 2'd1);
        step();
        clear();
        drain();

        // exception passthrough on req2 (pointer wraps to 0 afterwards)
        c = cyc;
        drive(2, 3'd4, 64'h1234, 1'b1, 64'hD);
        push(c + 2, 3'd4, 64'h1234, 1'b1, 64'hD, 2'd2);
        step();
        clear();
        req_ex_valid_i = '0;
        drain();

        // all three at once: order 0,1,2 with conflict for two cycles
        c = cyc;
        drive(0, 3'd1, 64'h100, 1'b0, 64'h0);
        drive(1, 3'd2, 64'h200, 1'b0, 64'h0);
        drive(2, 3'd3, 64'h300, 1'b0, 64'h0);
        push(c + 2, 3'd1, 64'h100, 1'b0, 64'h0, 2'd0);
        push(c + 3, 3'd2, 64'h200, 1'b0, 64'h0, 2'd1);
        push(c + 4, 3'd3, 64'h300, 1'b0, 64'h0, 2'd2);
        step();
        clear();
        step();
        chk("conflict_c2", 64'(conflict_o), 64'd1);
        step();
        chk("conflict_c3", 64'(conflict_o), 64'd1);
        step();
        chk("conflict_c4", 64'(conflict_o), 64'd0);
        drain();

        // second burst starts at index 0 again
        c = cyc;
        drive(0, 3'd4, 64'h400, 1'b0, 64'h0);
        drive(1, 3'd5, 64'h500, 1'b0, 64'h0);
        drive(2, 3'd6, 64'h600, 1'b0, 64'h0);
        push(c + 2, 3'd4, 64'h400, 1'b0, 64'h0, 2'd0);
        push(c + 3, 3'd5, 64'h500, 1'b0, 64'h0, 2'd1);
        push(c + 4, 3'd6, 64'h600, 1'b0, 64'h0, 2'd2);
        step();
        clear();
        drain();

        // slot 0 drained and refilled in the same cycle
        c = cyc;
        drive(0, 3'd3, 64'h33, 1'b0, 64'h0);
        push(c + 2, 3'd3, 64'h33, 1'b0, 64'h0, 2'd0);
        step();
        drive(0, 3'd7, 64'h77, 1'b0, 64'h0);
        #1 chk("ready_refill", 64'(req_ready_o[0]), 64'd1);
        push(c + 3, 3'd7, 64'h77, 1'b0, 64'h0, 2'd0);
        step();
        clear();
        drain();

        // flush with two slots occupied (pointer is 1 going in)
        drive(0, 3'd1, 64'hA0, 1'b0, 64'h0);
        drive(2, 3'd2, 64'hA2, 1'b0, 64'h0);
        step();
        clear();
        flush_i = 1'b1;
        drive(2, 3'd3, 64'hA3, 1'b0, 64'h0);
        #1 chk("ready_flush", 64'(req_ready_o), 64'b000);
        step();
        flush_i = 1'b0;
        clear();
        for (int k = 0; k < 3; k++) begin
            chk("flush_quiet", 64'(wb_valid_o), 64'd0);
            step();
        end
        chk("flush_quiet", 64'(wb_valid_o), 64'd0);

        // preserved pointer: burst goes 1,2,0
        c = cyc;
        drive(0, 3'd4, 64'hB0, 1'b0, 64'h0);
        drive(1, 3'd5, 64'hB1, 1'b0, 64'h0);
        drive(2, 3'd6, 64'hB2, 1'b0, 64'h0);
        push(c + 2, 3'd5, 64'hB1, 1'b0, 64'h0, 2'd1);
        push(c + 3, 3'd6, 64'hB2, 1'b0, 64'h0, 2'd2);
        push(c + 4, 3'd4, 64'hB0, 1'b0, 64'h0, 2'd0);
        step();
        clear();
        drain();

        c = cyc;
        drive(0, 3'd2, 64'h55, 1'b0, 64'h0);
        push(c + 2, 3'd2, 64'h55, 1'b0, 64'h0, 2'd0);
        step();
        clear();
        drain();

        // reset mid-operation discards held results
        drive(0, 3'd1, 64'hE0, 1'b0, 64'h0);
        drive(1, 3'd2, 64'hE1, 1'b0, 64'h0);
        step();
        clear();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("midrst_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("midrst_wb_data",  wb_data_o,       64'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("midrst_quiet", 64'(wb_valid_o), 64'd0);
        end

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares one scoreboard writeback port between several variable-latency functional units (e.g. multiplier, CSR buffer, CVXIF) so the issue stage needs fewer `NrWbPorts`. Each requester gets a one-entry holding register. Occupied entries are arbitrated round-robin onto a registered writeback port carrying trans_id, result data and exception. The block sits between the execute-stage units and the scoreboard writeback inputs (`trans_id_i`, `wbdata_i`, `ex_ex_i`, `wt_valid_i`).

## Interface
Parameters:
- `NrReq`, 3, number of requesters (≥2)
- `TransIdBits`, 3, width of trans_id (matches `TRANS_ID_BITS`)
- `DataW`, 64, result/cause width (`riscv::XLEN`)

Ports:
- `clk_i`  in  1  single clock, rising edge
- `rst_i`  in  1  reset, synchronous, active-high
- `flush_i`  in  1  drop all pending and outgoing results
- `req_valid_i`  in  NrReq  requester i has a result
- `req_ready_o`  out  NrReq  requester i may hand over its result this cycle
- `req_trans_id_i`  in  NrReq×TransIdBits  scoreboard id per requester
- `req_data_i`  in  NrReq×DataW  result per requester
- `req_ex_valid_i`  in  NrReq  exception flag per requester
- `req_ex_cause_i`  in  NrReq×DataW  exception cause per requester
- `wb_valid_o`  out  1  writeback valid (one-cycle pulse per result)
- `wb_trans_id_o`  out  TransIdBits  writeback id
- `wb_data_o`  out  DataW  writeback data
- `wb_ex_valid_o`  out  1  writeback exception flag
- `wb_ex_cause_o`  out  DataW  writeback exception cause
- `wb_grant_idx_o`  out  $clog2(NrReq)  requester that produced the current writeback
- `conflict_o`  out  1  perf pulse: more than one entry occupied this cycle

## Operation
- State per requester: `occ[i]` plus a holding register for {trans_id, data, ex_valid, ex_cause}. Global state: round-robin pointer `ptr` and the output register.
- Grant is combinational from `occ` and `ptr`. Search starts at index `ptr` upward with wrap-around, and the first occupied index wins. Exactly one grant or none.
- `req_ready_o[i] = !flush_i && (!occ[i] || gnt[i])`. It never depends on `req_valid_i`. A slot that is emptied by a grant accepts a new result in the same cycle.
- Accept when `req_valid_i[i] && req_ready_o[i]`: capture fields, `occ[i]`←1. If granted and not accepted: `occ[i]`←0.
- On grant g:
  - Output register loads entry g.
  - `wb_valid_o`←1 and `wb_grant_idx_o`←g.
  - `ptr` ← (g+1) mod NrReq.
- No grant: `wb_valid_o`←0, `ptr` holds. Data outputs hold their last value.
- The scoreboard has no backpressure. Every `wb_valid_o` pulse is consumed.
- `conflict_o` = popcount(`occ`) > 1, registered.
- `flush_i` (cycle n):
  - All `occ` cleared and `wb_valid_o`←0 at the next edge. No grant takes effect.
  - Inputs in cycle n are not accepted, because ready is low.
  - `ptr` is preserved.
- Priority: `rst_i` > `flush_i` > normal operation.
- Reset values:
  - `occ`=0, `ptr`=0.
  - `wb_valid_o`=0, `wb_ex_valid_o`=0, `wb_trans_id_o`=0, `wb_data_o`=0, `wb_ex_cause_o`=0, `wb_grant_idx_o`=0, `conflict_o`=0.
  - `req_ready_o` = all ones, combinational, once `rst_i` is low.

## Timing
- Latency: a result accepted at the edge ending cycle n is granted in cycle n+1 at the earliest. It appears on `wb_valid_o` in cycle n+2.
- Throughput: one writeback per cycle aggregate. A single uncontested requester sustains one result per cycle.
- Worst-case wait for an occupied entry is NrReq−1 grants. No starvation.
- All outputs except `req_ready_o` are registered.
- `rst_i` asserted mid-operation discards holding contents at the next edge. Nothing is emitted afterwards.

## Configuration
- `WB_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest occupied index wins. `ptr` is not implemented. Starvation of high indices is accepted; this mode is used for a dedicated low-latency multiplier on index 0.
- Undefined (default): round-robin as above.

## Test plan
- Reset, NrReq=3: assert `rst_i` 2 cycles with `req_valid_i`=3'b111 → all outputs 0. After release, `req_ready_o`=3'b111 and no `wb_valid_o` until 2 cycles after the first accept.
- Single requester: req1 sends id 5, data 0xDEAD in cycle 0 → `wb_valid_o`=1, id 5, data 0xDEAD, `wb_grant_idx_o`=1 in cycle 2. Then back-to-back ids 6,7 → writebacks in consecutive cycles 3,4.
- Contention, round-robin: all three accepted in cycle 0 with ids 1,2,3, `ptr`=0 → writebacks in cycles 2,3,4 ordered ids 1,2,3 and `conflict_o`=1 for 2 cycles. Next simultaneous burst starts with index 0 again because `ptr`=0 after wrap. With `WB_ARB_FIXED_PRIO_EN`, continuous req0 traffic → req2 never granted.
- Exception passthrough: req2 ex_valid=1, cause 0xD, id 4 → `wb_ex_valid_o`=1, `wb_ex_cause_o`=0xD, `wb_trans_id_o`=4. The next non-exception writeback shows `wb_ex_valid_o`=0.
- Flush: two entries occupied, `flush_i` pulsed 1 cycle → `req_ready_o`=0 during flush. No `wb_valid_o` in the following 3 cycles. A new req0 accepted after flush writes back 2 cycles later.
- Same-cycle free/refill: req0 occupied and granted while presenting a new id 7 → `req_ready_o[0]`=1, accepted. Id 7 writes back on the next grant to index 0.
